// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, its width,
// and a helper that sizes consumer index fields.
package mem_arbiter_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } arb_state_e;

    // Width of a consumer index; a single consumer still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
// Ports:
//   i_req   - per-consumer request vector
//   i_ptr   - index where the search starts (highest priority)
//   o_idx   - first requesting index at or after i_ptr, wrapping to 0
//   o_found - 1 when any request bit is set
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned IDX_W         = idx_width(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] i_req,
    input  logic [IDX_W-1:0]         i_ptr,
    output logic [IDX_W-1:0]         o_idx,
    output logic                     o_found
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            w_cand = IDX_W'((32'(i_ptr) + k) % NUM_CONSUMERS);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory read/write port among NUM_CONSUMERS
// requesters with a single outstanding transaction and round-robin grants.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   consumer_read_*               - per-consumer read request/response
//   consumer_write_*              - per-consumer write request/response
//   mem_read_*                    - memory-side read request/response
//   mem_write_*                   - memory-side write request/response
// All outputs are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,

    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,

    output logic                                     mem_write_valid,
    output logic [ADDR_BITS-1:0]                     mem_write_address,
    output logic [DATA_BITS-1:0]                     mem_write_data,
    input  logic                                     mem_write_ready
);

    localparam int unsigned      IDX_W    = idx_width(NUM_CONSUMERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

    arb_state_e       r_state, w_state_next;
    logic [IDX_W-1:0] r_grant, w_grant_next;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_next;
    logic [IDX_W-1:0] w_grant_inc;

    logic [NUM_CONSUMERS-1:0] w_req;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_pick_found;

    logic                                    w_mem_read_valid_next;
    logic [ADDR_BITS-1:0]                    w_mem_read_address_next;
    logic                                    w_mem_write_valid_next;
    logic [ADDR_BITS-1:0]                    w_mem_write_address_next;
    logic [DATA_BITS-1:0]                    w_mem_write_data_next;
    logic [NUM_CONSUMERS-1:0]                w_consumer_read_ready_next;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] w_consumer_read_data_next;
    logic [NUM_CONSUMERS-1:0]                w_consumer_write_ready_next;

    assign w_req       = consumer_read_valid | consumer_write_valid;
    assign w_grant_inc = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

    rr_picker #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .IDX_W         (IDX_W)
    ) u_rr_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_comb begin
        w_state_next                = r_state;
        w_grant_next                = r_grant;
        w_rr_ptr_next               = r_rr_ptr;
        w_mem_read_valid_next       = mem_read_valid;
        w_mem_read_address_next     = mem_read_address;
        w_mem_write_valid_next      = mem_write_valid;
        w_mem_write_address_next    = mem_write_address;
        w_mem_write_data_next       = mem_write_data;
        w_consumer_read_ready_next  = consumer_read_ready;
        w_consumer_read_data_next   = consumer_read_data;
        w_consumer_write_ready_next = consumer_write_ready;

        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_grant_next = w_pick_idx;
                    // A consumer asserting both read and write is served read first.
                    if (consumer_read_valid[w_pick_idx]) begin
                        w_state_next            = READ_WAITING;
                        w_mem_read_valid_next   = 1'b1;
                        w_mem_read_address_next = consumer_read_address[w_pick_idx];
                    end else begin
                        w_state_next             = WRITE_WAITING;
                        w_mem_write_valid_next   = 1'b1;
                        w_mem_write_address_next = consumer_write_address[w_pick_idx];
                        w_mem_write_data_next    = consumer_write_data[w_pick_idx];
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    w_mem_read_valid_next               = 1'b0;
                    w_consumer_read_data_next[r_grant]  = mem_read_data;
                    w_consumer_read_ready_next[r_grant] = 1'b1;
                    w_state_next                        = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    w_mem_write_valid_next               = 1'b0;
                    w_consumer_write_ready_next[r_grant] = 1'b1;
                    w_state_next                         = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!consumer_read_valid[r_grant]) begin
                    w_consumer_read_ready_next[r_grant] = 1'b0;
                    w_rr_ptr_next                       = w_grant_inc;
                    w_state_next                        = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!consumer_write_valid[r_grant]) begin
                    w_consumer_write_ready_next[r_grant] = 1'b0;
                    w_rr_ptr_next                        = w_grant_inc;
                    w_state_next                         = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state              <= IDLE;
            r_grant              <= '0;
            r_rr_ptr             <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
        end else begin
            r_state              <= w_state_next;
            r_grant              <= w_grant_next;
            r_rr_ptr             <= w_rr_ptr_next;
            mem_read_valid       <= w_mem_read_valid_next;
            mem_read_address     <= w_mem_read_address_next;
            mem_write_valid      <= w_mem_write_valid_next;
            mem_write_address    <= w_mem_write_address_next;
            mem_write_data       <= w_mem_write_data_next;
            consumer_read_ready  <= w_consumer_read_ready_next;
            consumer_read_data   <= w_consumer_read_data_next;
            consumer_write_ready <= w_consumer_write_ready_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned A = 8;
    localparam int unsigned D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [N-1:0]        rv, wv, rrdy, wrdy;
    logic [N-1:0][A-1:0] raddr, waddr;
    logic [N-1:0][D-1:0] wdata, rdata;
    logic                mrv, mwv, mrr, mwr;
    logic [A-1:0]        mra, mwa;
    logic [D-1:0]        mrd, mwd;

    mem_arbiter #(
        .ADDR_BITS     (A),
        .DATA_BITS     (D),
        .NUM_CONSUMERS (N)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (raddr),
        .consumer_read_ready    (rrdy),
        .consumer_read_data     (rdata),
        .consumer_write_valid   (wv),
        .consumer_write_address (waddr),
        .consumer_write_data    (wdata),
        .consumer_write_ready   (wrdy),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
    );

    int errors = 0;
    int checks = 0;

    logic [D-1:0] tb_mem    [256];
    logic [D-1:0] model_mem [256];

    bit mem_auto, cons_auto, hold_rand;
    logic [N-1:0]        snap_rv, snap_wv;
    logic [N-1:0][A-1:0] snap_raddr, snap_waddr;
    logic [N-1:0][D-1:0] snap_wdata;
    logic [N-1:0]        prev_rr, prev_wr;
    int                  done_q[$];   // i = read done by i, N+i = write done by i

    // Advance to the next falling edge, record completions, run the
    // automatic memory and consumer behaviour if enabled.
    task automatic tick();
        @(negedge clk);
        snap_rv = rv; snap_wv = wv;
        snap_raddr = raddr; snap_waddr = waddr; snap_wdata = wdata;
        for (int i = 0; i < N; i++) begin
            if (rrdy[i] && !prev_rr[i]) done_q.push_back(i);
            if (wrdy[i] && !prev_wr[i]) done_q.push_back(N + i);
        end
        prev_rr = rrdy; prev_wr = wrdy;
        if (mem_auto) begin
            mrr = 1'b0; mwr = 1'b0;
            mrd = D'($urandom);
            if (mrv && $urandom_range(0, 2) == 0) begin
                mrr = 1'b1; mrd = tb_mem[mra];
            end
            if (mwv && $urandom_range(0, 2) == 0) begin
                mwr = 1'b1; tb_mem[mwa] = mwd;
            end
        end
        if (cons_auto) begin
            for (int i = 0; i < N; i++) begin
                if (rrdy[i] && rv[i] && (!hold_rand || $urandom_range(0, 1) == 0)) rv[i] = 1'b0;
                if (wrdy[i] && wv[i] && (!hold_rand || $urandom_range(0, 1) == 0)) wv[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        done_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
        mrr = 1'b0; mwr = 1'b0; mrd = '0;
        mem_auto = 0; cons_auto = 0; hold_rand = 0;
        prev_rr = '0; prev_wr = '0;
        for (int a = 0; a < 256; a++) begin
            tb_mem[a] = D'($urandom); model_mem[a] = tb_mem[a];
        end
        tick(); tick();
        checks++; if (mrv !== 1'b0) begin errors++; $display("FAIL reset_mrv: got %0b expected 0", mrv); end
        checks++; if (mwv !== 1'b0) begin errors++; $display("FAIL reset_mwv: got %0b expected 0", mwv); end
        checks++; if (mra !== '0) begin errors++; $display("FAIL reset_mra: got %0h expected 0", mra); end
        checks++; if (mwa !== '0) begin errors++; $display("FAIL reset_mwa: got %0h expected 0", mwa); end
        checks++; if (mwd !== '0) begin errors++; $display("FAIL reset_mwd: got %0h expected 0", mwd); end
        checks++; if (rrdy !== '0) begin errors++; $display("FAIL reset_rrdy: got %0b expected 0", rrdy); end
        checks++; if (wrdy !== '0) begin errors++; $display("FAIL reset_wrdy: got %0b expected 0", wrdy); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", rdata); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({mrv, mwv, rrdy, wrdy} !== '0) begin
                errors++; $display("FAIL idle_quiet: got %0h expected 0", {mrv, mwv, rrdy, wrdy});
            end
        end
    endtask

    task automatic test_single_read();
        raddr[2] = 8'h10; rv[2] = 1'b1;
        tick();
        checks++; if (mrv !== 1'b1 || mra !== 8'h10) begin errors++; $display("FAIL sr_request: got valid=%0b addr=%0h expected 1/10", mrv, mra); end
        checks++; if (rrdy !== '0) begin errors++; $display("FAIL sr_early_ready: got %0b expected 0", rrdy); end
        tick(); tick();
        checks++; if (mrv !== 1'b1) begin errors++; $display("FAIL sr_hold: got %0b expected 1", mrv); end
        mrr = 1'b1; mrd = 8'h5A;
        tick();
        mrr = 1'b0; mrd = 8'hFF;
        checks++; if (rrdy !== 4'b0100) begin errors++; $display("FAIL sr_ready: got %0b expected 0100", rrdy); end
        checks++; if (rdata[2] !== 8'h5A) begin errors++; $display("FAIL sr_data: got %0h expected 5a", rdata[2]); end
        checks++; if (mrv !== 1'b0) begin errors++; $display("FAIL sr_drop_valid: got %0b expected 0", mrv); end
        tick();
        checks++; if (rrdy !== 4'b0100) begin errors++; $display("FAIL sr_ready_held: got %0b expected 0100", rrdy); end
        rv[2] = 1'b0;
        tick();
        checks++; if (rrdy !== '0) begin errors++; $display("FAIL sr_ready_clear: got %0b expected 0", rrdy); end
        tick();
        checks++; if (rdata[2] !== 8'h5A) begin errors++; $display("FAIL sr_data_hold: got %0h expected 5a", rdata[2]); end
    endtask

    // Last grant was consumer 2, so the search now starts at 3.
    task automatic test_wrap();
        mem_auto = 1; cons_auto = 1; hold_rand = 0;
        done_q.delete();
        raddr[1] = 8'h21; raddr[3] = 8'h23;
        rv[1] = 1'b1; rv[3] = 1'b1;
        for (int c = 0; c < 200 && done_q.size() < 2; c++) tick();
        tick(); tick();
        checks++;
        if (done_q.size() != 2) begin
            errors++; $display("FAIL wrap_count: got %0d expected 2", done_q.size());
        end else begin
            checks++; if (done_q[0] != 3 || done_q[1] != 1) begin errors++; $display("FAIL wrap_order: got %0d,%0d expected 3,1", done_q[0], done_q[1]); end
        end
        mem_auto = 0; cons_auto = 0; mrr = 1'b0; mwr = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_order[5];
        bit rq;
        exp_order = '{0, 1, 2, 3, 0};
        rq = 0;
        do_reset();
        mem_auto = 1; cons_auto = 1; hold_rand = 0;
        for (int i = 0; i < N; i++) raddr[i] = A'(8'h40 + i);
        rv = '1;
        for (int c = 0; c < 300 && done_q.size() < 5; c++) begin
            tick();
            if (!rq && done_q.size() >= 1 && !rv[0] && !rrdy[0]) begin
                rv[0] = 1'b1; rq = 1;
            end
        end
        tick(); tick();
        checks++;
        if (done_q.size() != 5) begin
            errors++; $display("FAIL rr_count: got %0d expected 5", done_q.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (done_q[j] != exp_order[j]) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", j, done_q[j], exp_order[j]);
                end
            end
        end
        mem_auto = 0; cons_auto = 0; mrr = 1'b0; mwr = 1'b0;
    endtask

    task automatic test_read_write();
        raddr[0] = 8'h20; waddr[0] = 8'h30; wdata[0] = 8'h77;
        rv[0] = 1'b1; wv[0] = 1'b1;
        tick();
        checks++; if (mrv !== 1'b1 || mwv !== 1'b0 || mra !== 8'h20) begin errors++; $display("FAIL rw_read_first: got rv=%0b wv=%0b addr=%0h expected 1/0/20", mrv, mwv, mra); end
        mrr = 1'b1; mrd = 8'h3C;
        tick();
        mrr = 1'b0;
        checks++; if (rrdy !== 4'b0001 || rdata[0] !== 8'h3C) begin errors++; $display("FAIL rw_read_done: got rdy=%0b data=%0h expected 0001/3c", rrdy, rdata[0]); end
        rv[0] = 1'b0;
        // stray write-ready outside WRITE_WAITING must be ignored
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        checks++; if (mwv !== 1'b0 || wrdy !== '0) begin errors++; $display("FAIL rw_gap: got wv=%0b wrdy=%0b expected 0/0", mwv, wrdy); end
        tick();
        checks++; if (mwv !== 1'b1 || mwa !== 8'h30 || mwd !== 8'h77) begin errors++; $display("FAIL rw_write: got v=%0b a=%0h d=%0h expected 1/30/77", mwv, mwa, mwd); end
        checks++; if (wrdy !== '0) begin errors++; $display("FAIL rw_write_early: got %0b expected 0", wrdy); end
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        checks++; if (wrdy !== 4'b0001 || mwv !== 1'b0) begin errors++; $display("FAIL rw_write_done: got rdy=%0b v=%0b expected 0001/0", wrdy, mwv); end
        wv[0] = 1'b0;
        tick();
        checks++; if (wrdy !== '0) begin errors++; $display("FAIL rw_write_clear: got %0b expected 0", wrdy); end
    endtask

    task automatic test_reset_mid();
        raddr[1] = 8'h44; rv[1] = 1'b1;
        tick();
        checks++; if (mrv !== 1'b1) begin errors++; $display("FAIL rm_pre: got %0b expected 1", mrv); end
        reset = 1'b1;
        tick();
        checks++; if (mrv !== 1'b0 || mra !== '0) begin errors++; $display("FAIL rm_mem: got v=%0b a=%0h expected 0/0", mrv, mra); end
        checks++; if (rdata !== '0 || rrdy !== '0 || wrdy !== '0) begin errors++; $display("FAIL rm_consumer: got data=%0h rrdy=%0b wrdy=%0b expected 0", rdata, rrdy, wrdy); end
        reset = 1'b0; rv[1] = 1'b0;
        mrr = 1'b1; mrd = 8'h99;
        tick(); tick();
        mrr = 1'b0;
        checks++; if (rrdy !== '0 || rdata[1] !== '0 || mrv !== 1'b0) begin errors++; $display("FAIL rm_stray: got rrdy=%0b data=%0h v=%0b expected 0", rrdy, rdata[1], mrv); end
        raddr[3] = 8'h5C; rv[3] = 1'b1;
        tick();
        checks++; if (mrv !== 1'b1 || mra !== 8'h5C) begin errors++; $display("FAIL rm_after: got v=%0b a=%0h expected 1/5c", mrv, mra); end
        mrr = 1'b1; mrd = 8'h11;
        tick();
        mrr = 1'b0;
        checks++; if (rrdy !== 4'b1000 || rdata[3] !== 8'h11) begin errors++; $display("FAIL rm_after_done: got rdy=%0b d=%0h expected 1000/11", rrdy, rdata[3]); end
        rv[3] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int  model_ptr, exp_g, eg, c;
        bit  exp_rd, found, prev_mrv, prev_mwv;
        logic [A-1:0] exp_addr;
        logic [D-1:0] exp_wdata;
        int  e, op;
        do_reset();
        for (int a = 0; a < 256; a++) model_mem[a] = tb_mem[a];
        mem_auto = 1; cons_auto = 1; hold_rand = 1;
        model_ptr = 0; exp_g = -1; exp_rd = 0; exp_addr = '0; exp_wdata = '0;
        prev_mrv = 0; prev_mwv = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if ((mrv && !prev_mrv) || (mwv && !prev_mwv)) begin
                found = 0; eg = 0;
                for (int k = 0; k < N; k++) begin
                    c = (model_ptr + k) % N;
                    if (!found && (snap_rv[c] || snap_wv[c])) begin found = 1; eg = c; end
                end
                checks++;
                if (!found) begin
                    errors++; $display("FAIL rnd_spurious_grant: got v=%0b%0b expected no request", mrv, mwv);
                end else begin
                    exp_g = eg; exp_rd = snap_rv[eg];
                    exp_addr = exp_rd ? snap_raddr[eg] : snap_waddr[eg];
                    exp_wdata = snap_wdata[eg];
                    checks++;
                    if ({mrv, mwv} !== (exp_rd ? 2'b10 : 2'b01)) begin
                        errors++; $display("FAIL rnd_op: got %0b%0b expected rd=%0b for consumer %0d", mrv, mwv, exp_rd, eg);
                    end
                    checks++;
                    if (exp_rd ? (mra !== exp_addr) : (mwa !== exp_addr || mwd !== exp_wdata)) begin
                        errors++; $display("FAIL rnd_addr: got ra=%0h wa=%0h wd=%0h expected a=%0h d=%0h", mra, mwa, mwd, exp_addr, exp_wdata);
                    end
                end
            end
            if (done_q.size() > 0) begin
                e = done_q.pop_front();
                checks++;
                if ((e % N) != exp_g || (e < N) != exp_rd) begin
                    errors++; $display("FAIL rnd_completion: got code %0d expected consumer %0d rd=%0b", e, exp_g, exp_rd);
                end
                checks++;
                if (exp_rd) begin
                    if (rdata[e % N] !== model_mem[exp_addr]) begin
                        errors++; $display("FAIL rnd_read_data: got %0h expected %0h", rdata[e % N], model_mem[exp_addr]);
                    end
                end else begin
                    model_mem[exp_addr] = exp_wdata;
                    if (tb_mem[exp_addr] !== exp_wdata) begin
                        errors++; $display("FAIL rnd_write_data: got %0h expected %0h", tb_mem[exp_addr], exp_wdata);
                    end
                end
                model_ptr = (exp_g + 1) % N;
            end
            checks++;
            if ($countones({rrdy, wrdy}) > 1) begin
                errors++; $display("FAIL rnd_onehot: got rrdy=%0b wrdy=%0b expected at most one", rrdy, wrdy);
            end
            prev_mrv = mrv; prev_mwv = mwv;
            if (cyc < 2500) begin
                for (int i = 0; i < N; i++) begin
                    if (!rv[i] && !wv[i] && !rrdy[i] && !wrdy[i] && $urandom_range(0, 3) == 0) begin
                        op = $urandom_range(0, 2);
                        if (op != 1) begin rv[i] = 1'b1; raddr[i] = A'($urandom_range(0, 15)); end
                        if (op != 0) begin
                            wv[i] = 1'b1; waddr[i] = A'($urandom_range(0, 15)); wdata[i] = D'($urandom);
                        end
                    end
                end
            end
        end
        checks++;
        if ((rv | wv) !== '0 || done_q.size() != 0) begin
            errors++; $display("FAIL rnd_drain: got pending rv=%0b wv=%0b expected none", rv, wv);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_wrap();
        test_round_robin();
        test_read_write();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, meaning the memory address width.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning the memory data width.
REQ-003 The block SHALL have parameter NUM_CONSUMERS, default 4, meaning the number of requester channels (LSUs or fetchers).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named as follows:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-005 Consumer read ports SHALL be:
- consumer_read_valid  input  [NUM_CONSUMERS]  read request.
- consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  read address.
- consumer_read_ready  output  [NUM_CONSUMERS]  read complete.
- consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  returned data.
REQ-006 Consumer write ports SHALL be:
- consumer_write_valid  input  [NUM_CONSUMERS]  write request.
- consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS]  write address.
- consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  write data.
- consumer_write_ready  output  [NUM_CONSUMERS]  write complete.
REQ-007 Memory-side read ports SHALL be:
- mem_read_valid  output  1  read request.
- mem_read_address  output  ADDR_BITS  read address.
- mem_read_ready  input  1  read done.
- mem_read_data  input  DATA_BITS  read data.
REQ-008 Memory-side write ports SHALL be:
- mem_write_valid  output  1  write request.
- mem_write_address  output  ADDR_BITS  write address.
- mem_write_data  output  DATA_BITS  write data.
- mem_write_ready  input  1  write done.

Function
REQ-009 The block SHALL share one memory port among NUM_CONSUMERS requesters, with at most one outstanding transaction at a time.
REQ-010 The FSM SHALL have the states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING and WRITE_RELAYING.
REQ-011 In IDLE, the block SHALL grant the first consumer with read_valid or write_valid, searching from rr_ptr upward and wrapping from NUM_CONSUMERS-1 to 0.
REQ-012 If the granted consumer asserts both read_valid and write_valid, the block SHALL serve the read first.
REQ-013 On a grant at edge N, the block SHALL latch the grant index and drive mem_*_valid=1 with the granted address (and write data) from edge N.
REQ-014 The block SHALL then enter READ_WAITING or WRITE_WAITING and hold the memory request stable until mem_*_ready=1.
REQ-015 When mem_read_ready=1 in READ_WAITING, at the next edge the block SHALL drop mem_read_valid, register mem_read_data into consumer_read_data[g], set consumer_read_ready[g]=1, and enter READ_RELAYING.
REQ-016 When mem_write_ready=1 in WRITE_WAITING, at the next edge the block SHALL drop mem_write_valid, set consumer_write_ready[g]=1, and enter WRITE_RELAYING.
REQ-017 In a *_RELAYING state, the block SHALL hold consumer_*_ready[g]=1 while consumer_*_valid[g]=1.
REQ-018 Once consumer_*_valid[g]=0 in a *_RELAYING state, at the next edge the block SHALL clear the ready, set rr_ptr=(g+1) mod NUM_CONSUMERS, and return to IDLE.
REQ-019 Minimum round trip SHALL be: request seen at edge 0, mem valid from edge 0, mem_ready sampled at edge k, consumer ready from edge k, next grant no earlier than edge k+2.
REQ-020 mem_*_ready asserted outside the matching WAITING state SHALL be ignored.
REQ-021 A consumer dropping valid while in WAITING SHALL NOT abort the memory transaction; ready SHALL pulse for one cycle in RELAYING, then the FSM SHALL return to IDLE.
REQ-022 consumer_read_data[i] SHALL hold its last value until the next read completes for consumer i.
REQ-023 At most one consumer_*_ready bit SHALL be high in any cycle.
REQ-024 With no valid requests, the block SHALL stay in IDLE with all valid/ready outputs at 0.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set the state to IDLE, rr_ptr to 0, grant to 0, and all mem_*_valid, consumer_*_ready, addresses and data outputs to 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction, and mem valid SHALL be low from the edge at which reset is sampled.

Structure
REQ-027 The state enum typedef and the state-width constant SHALL live in the shared GPU package.
REQ-028 A combinational sub-module rr_picker SHALL compute the next grant index and a found flag from the request vector and rr_ptr.

Verification
REQ-029 Single read: consumer 2 reads addr 0x10, memory returns 0x5A after 3 cycles -> consumer_read_data[2]=0x5A and consumer_read_ready[2]=1 until valid drops.
REQ-030 Round robin: all 4 consumers request reads simultaneously from reset -> grants occur in order 0,1,2,3, then 0 again on re-request.
REQ-031 Wrap: rr_ptr=3 with consumers 1 and 3 requesting -> consumer 3 is granted first, then consumer 1.
REQ-032 Simultaneous read and write: consumer 0 asserts both (read 0x20, write 0x30 data 0x77) -> the read completes first, then mem_write_address=0x30 and mem_write_data=0x77.
REQ-033 Reset mid-operation: reset asserted in READ_WAITING -> at the next edge all outputs are 0 and the state is IDLE; a stray mem_read_ready afterwards is ignored.
